// File: rtl/arith_multicycle.sv
// arith_multicycle: multicycle MIPS-subset arithmetic machine; define ARITH_SLT_EN to add slt/slti
module arith_multicycle #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  output logic                     except,
  output logic [31:0]              retired,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [1:0] {FETCH, EXEC, EXCEPT} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_pc;
  logic [31:0]      r_ir, r_retired;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [5:0]       w_op, w_fn;
  logic [AW-1:0]    w_rs, w_rt, w_rd, w_dst;
  logic [WIDTH-1:0] w_a, w_b, w_sext, w_zext, w_res;
  logic             w_legal;
  assign w_op      = r_ir[31:26];
  assign w_fn      = r_ir[5:0];
  assign w_rs      = r_ir[21 +: AW];
  assign w_rt      = r_ir[16 +: AW];
  assign w_rd      = r_ir[11 +: AW];
  assign w_a       = r_regs[w_rs];
  assign w_b       = r_regs[w_rt];
  assign w_sext    = WIDTH'($signed(r_ir[15:0]));
  assign w_zext    = WIDTH'(r_ir[15:0]);
  // request is suppressed while reset is held low, whatever the state register holds
  assign imem_req  = (r_state == FETCH) && reset;
  assign imem_addr = r_pc;
  assign except    = (r_state == EXCEPT);
  assign retired   = r_retired;
  assign dbg_data  = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
  // decode IR: R-type writes rd, immediate forms write rt; unknown encodings are illegal
  always_comb begin
    w_legal = 1'b1;
    w_dst   = w_rd;
    w_res   = '0;
    if (w_op == 6'h00) begin
      case (w_fn)
        6'h20:   w_res = w_a + w_b;
        6'h22:   w_res = w_a - w_b;
        6'h24:   w_res = w_a & w_b;
        6'h25:   w_res = w_a | w_b;
        6'h26:   w_res = w_a ^ w_b;
        6'h27:   w_res = ~(w_a | w_b);
`ifdef ARITH_SLT_EN
        6'h2a:   w_res = WIDTH'($signed(w_a) < $signed(w_b));
`endif
        default: w_legal = 1'b0;
      endcase
    end else begin
      w_dst = w_rt;
      case (w_op)
        6'h08:   w_res = w_a + w_sext;
        6'h0c:   w_res = w_a & w_zext;
        6'h0d:   w_res = w_a | w_zext;
        6'h0e:   w_res = w_a ^ w_zext;
`ifdef ARITH_SLT_EN
        6'h0a:   w_res = WIDTH'($signed(w_a) < $signed(w_sext));
`endif
        default: w_legal = 1'b0;
      endcase
    end
  end
  // next-state: fetch waits for ack, exec returns to fetch or traps, except absorbs
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = imem_ack ? EXEC : FETCH;
      EXEC:    w_next = w_legal ? FETCH : EXCEPT;
      default: w_next = EXCEPT;
    endcase
  end
  // state register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end
  // datapath: IR latch on ack, architectural update when a legal instruction ends EXEC
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == FETCH && imem_ack) r_ir <= imem_data;
      if (r_state == EXEC && w_legal) begin
        r_pc      <= r_pc + WIDTH'(4);
        r_retired <= r_retired + 32'd1;
        if (w_dst != '0) r_regs[w_dst] <= w_res;
      end
    end
  end
endmodule

// File: tb/tb_arith_multicycle.sv
// tb_arith_multicycle: randomized self-checking bench against an instruction-level reference model
module tb_arith_multicycle;
`ifdef ARITH_SLT_EN
  localparam bit SLT = 1'b1;
`else
  localparam bit SLT = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic        imem_req, except;
  logic [31:0] imem_addr, retired, dbg_data;
  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ret;
  logic        m_exc;

  arith_multicycle #(.WIDTH(32), .NREGS(32)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .except(except), .retired(retired),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'($urandom), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // architectural semantics of one instruction word against the model register file
  function automatic bit ref_exec(input logic [31:0] w, output int d, output logic [31:0] v);
    logic [31:0] a, b, se, ze;
    a  = m_regs[w[25:21]];
    b  = m_regs[w[20:16]];
    se = 32'($signed(w[15:0]));
    ze = 32'(w[15:0]);
    v  = '0;
    if (w[31:26] == 6'h00) begin
      d = int'(w[15:11]);
      case (w[5:0])
        6'h20: v = a + b;
        6'h22: v = a - b;
        6'h24: v = a & b;
        6'h25: v = a | b;
        6'h26: v = a ^ b;
        6'h27: v = ~(a | b);
        6'h2a: begin v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; return SLT; end
        default: return 1'b0;
      endcase
    end else begin
      d = int'(w[20:16]);
      case (w[31:26])
        6'h08: v = a + se;
        6'h0c: v = a & ze;
        6'h0d: v = a | ze;
        6'h0e: v = a ^ ze;
        6'h0a: begin v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; return SLT; end
        default: return 1'b0;
      endcase
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    logic [5:0] ops [4] = '{6'h08, 6'h0c, 6'h0d, 6'h0e};
    int k = $urandom_range(0, SLT ? 11 : 9);
    int rs = $urandom_range(0, 31), rt = $urandom_range(0, 31), rd = $urandom_range(0, 31);
    logic [15:0] imm = 16'($urandom);
    if (k < 6)  return rtype(rs, rt, rd, fns[k]);
    if (k < 10) return itype(ops[k-6], rs, rt, imm);
    if (k == 10) return rtype(rs, rt, rd, 6'h2a);
    return itype(6'h0a, rs, rt, imm);
  endfunction

  // serve one fetch after wt wait cycles, let it execute, then compare with the model
  task automatic fetch_exec(input logic [31:0] w, input int wt);
    int st, d;
    logic [31:0] v;
    st = cyc;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc)
      $display("FAIL fetch_start req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, m_pc);
    for (int i = 0; i < wt; i++) begin
      imem_ack = 1'b0;
      imem_data = $urandom;
      @(negedge clock);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        fails++;
        $display("FAIL wait_hold req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, m_pc);
      end
    end
    imem_ack = 1'b1;
    imem_data = w;
    @(negedge clock);
    imem_ack = 1'b0;
    imem_data = $urandom;
    @(negedge clock);
    if (ref_exec(w, d, v)) begin
      if (d != 0) m_regs[d] = v;
      m_pc  = m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
    end else begin
      m_exc = 1'b1;
    end
    tests++;
    if (retired !== m_ret || except !== m_exc || imem_req !== !m_exc || imem_addr !== m_pc) begin
      fails++;
      $display("FAIL post_exec w=%h ret=%0d exc=%b req=%b addr=%h expected ret=%0d exc=%b req=%b addr=%h",
               w, retired, except, imem_req, imem_addr, m_ret, m_exc, !m_exc, m_pc);
    end
    tests++;
    if (cyc - st !== wt + 2) begin
      fails++;
      $display("FAIL instr_cycles got=%0d expected=%0d", cyc - st, wt + 2);
    end
    dbg_addr = 5'(d);
    #1;
    tests++;
    if (dbg_data !== m_regs[d]) begin
      fails++;
      $display("FAIL dest_reg r%0d got=%h expected=%h", d, dbg_data, m_regs[d]);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      tests++;
      if (dbg_data !== m_regs[i]) begin
        fails++;
        $display("FAIL %s r%0d got=%h expected=%h", tag, i, dbg_data, m_regs[i]);
      end
    end
  endtask

  // hold reset two cycles (optionally with a colliding ack) and release it at a negedge
  task automatic do_reset(input bit ack);
    @(negedge clock);
    reset = 1'b0;
    imem_ack = ack;
    imem_data = itype(6'h08, 0, 5, 16'h0001);
    @(negedge clock);
    imem_ack = 1'b0;
    @(negedge clock);
    tests++;
    if (imem_req !== 1'b0 || except !== 1'b0 || retired !== 32'd0 || imem_addr !== 32'd0) begin
      fails++;
      $display("FAIL in_reset req=%b exc=%b ret=%0d addr=%h expected 0 0 0 0", imem_req, except, retired, imem_addr);
    end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0;
    m_ret = '0;
    m_exc = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      fails++;
      $display("FAIL first_req req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    check_regs("reset_regs");
  endtask

  task automatic run_basic(input int wt);
    int st = cyc;
    fetch_exec(itype(6'h08, 0, 1, 16'd5), wt);
    fetch_exec(itype(6'h08, 0, 2, 16'hfffd), wt);
    fetch_exec(rtype(1, 2, 3, 6'h20), wt);
    tests++;
    if (cyc - st !== 3 * (wt + 2) || retired !== 32'd3 || m_regs[3] !== 32'd2 || m_regs[2] !== 32'hffff_fffd) begin
      fails++;
      $display("FAIL basic_prog cycles=%0d ret=%0d expected cycles=%0d ret=3", cyc - st, retired, 3 * (wt + 2));
    end
    check_regs("basic_regs");
  endtask

  task automatic test_reset();
    do_reset(1'b0);
  endtask

  task automatic test_basic();
    run_basic(0);
  endtask

  task automatic test_logic();
    fetch_exec(itype(6'h0d, 0, 4, 16'hffff), 0);
    fetch_exec(itype(6'h0c, 4, 5, 16'h8000), 0);
    fetch_exec(rtype(0, 0, 6, 6'h27), 1);
    fetch_exec(rtype(4, 1, 8, 6'h22), 0);
    fetch_exec(rtype(4, 6, 9, 6'h26), 2);
    check_regs("logic_regs");
  endtask

  task automatic test_r0_and_except();
    fetch_exec(itype(6'h08, 0, 0, 16'd7), 0);
    fetch_exec(itype(6'h3f, 1, 2, 16'h1234), 1);
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      imem_data = $urandom;
      @(negedge clock);
      tests++;
      if (except !== 1'b1 || imem_req !== 1'b0 || retired !== m_ret || imem_addr !== m_pc) begin
        fails++;
        $display("FAIL except_frozen exc=%b req=%b ret=%0d addr=%h expected exc=1 req=0 ret=%0d addr=%h",
                 except, imem_req, retired, imem_addr, m_ret, m_pc);
      end
    end
    imem_ack = 1'b0;
    check_regs("except_regs");
  endtask

  task automatic test_reset_in_except();
    do_reset(1'b0);
    fetch_exec(itype(6'h08, 0, 10, 16'd42), 0);
  endtask

  task automatic test_wait();
    do_reset(1'b0);
    run_basic(3);
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    do_reset(1'b1);
    fetch_exec(itype(6'h0e, 0, 11, 16'h00ff), 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) fetch_exec(rand_legal(), $urandom_range(0, 3));
    check_regs("random_regs");
  endtask

  task automatic test_slt();
    do_reset(1'b0);
    fetch_exec(itype(6'h08, 0, 1, 16'd5), 0);
    fetch_exec(itype(6'h08, 0, 2, 16'hfffd), 0);
    fetch_exec(itype(6'h08, 0, 7, 16'd9), 0);
    fetch_exec(rtype(2, 1, 7, 6'h2a), 0);
    dbg_addr = 5'd7;
    #1;
    tests++;
    if (dbg_data !== (SLT ? 32'd1 : 32'd9) || except !== !SLT) begin
      fails++;
      $display("FAIL slt r7=%h exc=%b expected r7=%h exc=%b", dbg_data, except, SLT ? 32'd1 : 32'd9, !SLT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_logic();
    test_r0_and_except();
    test_reset_in_except();
    test_wait();
    test_reset_mid_fetch();
    test_random();
    test_slt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule
